// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one instruction-memory read at a
// time, and hands fetched words to decode over a valid/ready handshake.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_OUT,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic        kill;
    logic        kill_n;
    logic        valid_n;
    logic [31:0] ifpc_n;
    logic [31:0] instr_n;
    logic        fault_n;
    logic [31:0] cnt_n;

    // 32-bit add with the carry discarded, so the top word address wraps to zero.
    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        valid_n = if_valid;
        ifpc_n  = if_pc;
        instr_n = if_instr;
        fault_n = fetch_fault;
        cnt_n   = fetch_cnt;

        case (state)
            S_IDLE:  state_n = S_FETCH;
            S_FETCH: state_n = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = S_FETCH;
                    end else begin
                        instr_n = imem_rdata;
                        ifpc_n  = pc;
                        valid_n = 1'b1;
                        pc_n    = pc_inc(pc);
                        state_n = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (if_ready) begin
                    valid_n = 1'b0;
                    cnt_n   = fetch_cnt + 32'd1;
                    state_n = S_FETCH;
                end
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
        endcase

        // Redirects override the normal step; a transfer already decided in OUT still counts.
        if (redirect_valid && (state != S_FAULT)) begin
            valid_n = 1'b0;
            instr_n = if_instr;
            if (redirect_pc[1:0] != 2'b00) begin
                state_n = S_FAULT;
                pc_n    = pc;
                kill_n  = 1'b0;
                ifpc_n  = redirect_pc;
                fault_n = 1'b1;
            end else begin
                pc_n   = redirect_pc;
                ifpc_n = if_pc;
                case (state)
                    S_FETCH: begin
                        kill_n  = 1'b1;
                        state_n = S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            kill_n  = 1'b0;
                            state_n = S_FETCH;
                        end else begin
                            kill_n  = 1'b1;
                            state_n = S_WAIT;
                        end
                    end
                    default: state_n = S_FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= 32'd0;
            if_instr    <= 32'd0;
            fetch_fault <= 1'b0;
            fetch_cnt   <= 32'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            kill        <= kill_n;
            if_valid    <= valid_n;
            if_pc       <= ifpc_n;
            if_instr    <= instr_n;
            fetch_fault <= fault_n;
            fetch_cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a variable-latency memory model, directed phases
// from the test plan, then randomized ready/redirect traffic.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr),
        .fetch_fault(fetch_fault), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents: fixed program words at 0/4/8, address-dependent hash elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'h0020_81B3;
            default: return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
        endcase
    endfunction

    // Instruction memory: one outstanding read, latency cur_lat (0 = random 1..4).
    logic        noise_en = 1'b0;
    int          cur_lat  = 1;
    logic        req_s;
    logic        rst_s;
    logic [31:0] addr_s;
    logic        pend;
    logic [31:0] paddr;
    int          mcnt;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        pend        = 1'b0;
        paddr       = 32'd0;
        mcnt        = 0;
        forever begin
            @(negedge clk);
            req_s  = imem_req;
            addr_s = imem_addr;
            rst_s  = reset;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!rst_s) begin
                pend = 1'b0;
                if (noise_en) begin
                    imem_rvalid = ($urandom_range(0, 1) == 1);
                    imem_rdata  = $urandom;
                end
            end else begin
                if (req_s) begin
                    check("one_outstanding", 32'(pend), 32'd0);
                    pend  = 1'b1;
                    paddr = addr_s;
                    mcnt  = (cur_lat == 0) ? int'($urandom_range(1, 4)) : cur_lat;
                end
                if (pend) begin
                    if (mcnt <= 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = memf(paddr);
                        pend        = 1'b0;
                    end else begin
                        mcnt--;
                    end
                end
            end
        end
    end

    // Reference model: the next transfer is the word at the architectural next PC,
    // which is the last transferred PC + 4, or the target of the latest aligned redirect.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          ncnt     = 0;
    logic        m_fault  = 1'b0;
    logic [31:0] fault_pc = 32'd0;
    logic        in_rst   = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    int          xfer_cyc[3];

    task automatic push_exp(input logic [31:0] a);
        exp_t t;
        t.pc    = a;
        t.instr = memf(a);
        q.push_back(t);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (in_rst) begin
                check("rst_imem_req", 32'(imem_req), 32'd0);
                check("rst_if_valid", 32'(if_valid), 32'd0);
                check("rst_if_pc", if_pc, 32'd0);
                check("rst_if_instr", if_instr, 32'd0);
                check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
                check("rst_fetch_cnt", fetch_cnt, 32'd0);
            end
            in_rst    = 1'b1;
            q.delete();
            push_exp(RESET_PC);
            ncnt      = 0;
            m_fault   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            in_rst = 1'b0;
            check("fetch_cnt", fetch_cnt, 32'(ncnt));
            check("req_while_valid", 32'(imem_req & if_valid), 32'd0);
            check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            if (m_fault) begin
                check("fault_no_req", 32'(imem_req), 32'd0);
                check("fault_no_valid", 32'(if_valid), 32'd0);
                check("fault_if_pc", if_pc, fault_pc);
            end
            if (hold_prev) begin
                check("hold_valid", 32'(if_valid), 32'd1);
                check("hold_pc", if_pc, prev_pc);
                check("hold_instr", if_instr, prev_instr);
            end
            hold_prev  = if_valid && !if_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
            if (if_valid && if_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got pc %h, expected no transfer", if_pc);
                    push_exp(if_pc + 32'd4);
                end else begin
                    e = q.pop_front();
                    check("xfer_pc", if_pc, e.pc);
                    check("xfer_instr", if_instr, e.instr);
                    push_exp(e.pc + 32'd4);
                end
                if (ncnt < 3) xfer_cyc[ncnt] = cyc;
                ncnt++;
            end
            if (redirect_valid && !m_fault) begin
                q.delete();
                if (redirect_pc[1:0] != 2'b00) begin
                    m_fault  = 1'b1;
                    fault_pc = redirect_pc;
                end else begin
                    push_exp(redirect_pc);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_req(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_cnt(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (ncnt >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        bit          ok;
        int          base;
        logic [31:0] held_pc;

        reset          = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        noise_en       = 1'b1;
        tick(4);

        // Release: one IDLE cycle, then the first request at RESET_PC.
        reset    = 1'b1;
        noise_en = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        @(posedge clk);
        #2;

        // Streaming at latency 1 with decode always ready.
        wait_cnt(3, 40, ok);
        check("stream_done", 32'(ok), 32'd1);
        if_ready = 1'b0;
        check("stream_cnt", fetch_cnt, 32'd3);
        check("stream_gap1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
        check("stream_gap2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd3);

        // Backpressure while presenting.
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("bp_valid_seen", 32'(ok), 32'd1);
        held_pc = if_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(if_valid), 32'd1);
            check("bp_no_req", 32'(imem_req), 32'd0);
        end
        if_ready = 1'b1;
        wait_req(10, ok);
        check("bp_req_seen", 32'(ok), 32'd1);
        check("bp_next_addr", imem_addr, held_pc + 32'd4);
        check("bp_cnt", fetch_cnt, 32'd4);

        // Kill an in-flight fetch in its second WAIT cycle.
        cur_lat = 3;
        base    = ncnt;
        tick(2);
        pulse_redirect(32'h0000_0100);
        wait_req(20, ok);
        check("kill_req_seen", 32'(ok), 32'd1);
        check("kill_next_addr", imem_addr, 32'h0000_0100);
        wait_cnt(base + 1, 30, ok);
        check("kill_xfer", 32'(ok), 32'd1);

        // Wrap past the top of the address space.
        cur_lat = 1;
        pulse_redirect(32'hFFFF_FFFC);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && (imem_addr == 32'h0)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wrap_addr_zero", 32'(ok), 32'd1);

        // Randomized latency, backpressure and aligned redirects.
        cur_lat = 0;
        for (int i = 0; i < 800; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                         : ($urandom & 32'hFFFF_FFFC);
            tick();
        end
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        base           = ncnt;
        wait_cnt(base + 2, 60, ok);
        check("random_drain", 32'(ok), 32'd1);

        // Misaligned redirect: sticky fault until reset.
        base = ncnt;
        pulse_redirect(32'h0000_0102);
        tick(2);
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_if_pc", if_pc, 32'h0000_0102);
        check("mis_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("mis_no_req", 32'(imem_req), 32'd0);
            tick();
        end
        pulse_redirect(32'h0000_0200);
        tick(5);
        check("mis_stays_fault", 32'(fetch_fault), 32'd1);
        check("mis_stays_pc", if_pc, 32'h0000_0102);
        check("mis_stays_noreq", 32'(imem_req), 32'd0);
        check("mis_cnt_frozen", fetch_cnt, 32'(base));

        // Reset clears the fault and fetching restarts.
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        wait_cnt(2, 40, ok);
        check("restart_xfers", 32'(ok), 32'd1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, expected finish within 60000 cycles");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction memory's read port. It issues one read at a time, waits a variable number of cycles for the response, and presents the fetched word with its PC to decode over a valid/ready handshake. It also absorbs branch/jump redirects and flags misaligned targets. It replaces free-running `pc + 4` fetch and sits between PC/INS_MEM and decode/immGen.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: `reset == 0` at a rising edge resets the block.
- imem_req  out  1  read strobe; the memory samples imem_addr on the edge where imem_req=1.
- imem_addr  out  32  read address; always equals the internal pc register.
- imem_rvalid  in  1  response valid; earliest one cycle after the request; at most one per request.
- imem_rdata  in  32  response word; qualified by imem_rvalid.
- redirect_valid  in  1  one-cycle pulse: load redirect_pc into the PC.
- redirect_pc  in  32  new fetch target.
- if_valid  out  1  fetched instruction available (registered).
- if_ready  in  1  decode accepts; a transfer occurs when if_valid & if_ready.
- if_pc  out  32  address of the presented instruction.
- if_instr  out  32  presented instruction word.
- fetch_fault  out  1  sticky misaligned-redirect fault.
- fetch_cnt  out  32  count of completed transfers; wraps modulo 2^32.

## Operation
- State machine: IDLE, FETCH, WAIT, OUT, FAULT.
- Reset (`reset == 0`):
  - State goes to IDLE, pc goes to RESET_PC, kill flag cleared.
  - Outputs: imem_req=0, if_valid=0, if_pc=0, if_instr=0, fetch_fault=0, fetch_cnt=0.
  - Reset overrides everything, including mid-WAIT or OUT.
  - Instruction memory shares this reset and drops any pending response.
- IDLE: always goes to FETCH on the next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc; next state WAIT.
  - imem_req is 0 in every other state.
- WAIT: waits for imem_rvalid.
  - If kill=0 when the response arrives: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4; go to OUT.
  - If kill=1 when the response arrives: discard it, clear kill, go to FETCH.
- OUT:
  - if_valid, if_pc and if_instr are held stable while if_ready=0.
  - On a transfer: if_valid<=0, fetch_cnt<=fetch_cnt+1; go to FETCH.
- FAULT:
  - imem_req=0, if_valid=0, fetch_fault=1.
  - imem_rvalid and redirect_valid are ignored.
  - Only reset exits FAULT.
- Redirect (redirect_valid=1) has priority over all normal transitions. Actions by state:
  - IDLE, FETCH, WAIT, OUT: pc<=redirect_pc.
  - FETCH: the request issued this cycle is in flight; set kill=1 and go to WAIT.
  - WAIT with imem_rvalid=0: set kill=1 and stay in WAIT.
  - WAIT with imem_rvalid=1 in the same cycle: discard the response and go to FETCH.
  - OUT: if_valid<=0 and go to FETCH. If if_ready=1 in the same cycle, the transfer still counts: fetch_cnt increments and decode keeps the word.
- Misaligned redirect (redirect_pc[1:0] != 0), in any non-FAULT state:
  - Go to FAULT; if_pc<=redirect_pc, if_valid<=0, fetch_fault<=1.
  - pc is not loaded.
  - Any in-flight response is dropped.
- Arithmetic: pc+4 is a 32-bit add with no carry out, so 32'hFFFF_FFFC wraps to 32'h0000_0000. fetch_cnt wraps the same way.

## Timing
- Minimum throughput is 3 cycles per instruction: FETCH, WAIT (rvalid in the first WAIT cycle), then OUT with if_ready=1.
- Latency: if_valid rises on the edge that samples imem_rvalid, i.e. 2 cycles after the imem_req cycle when memory latency is 1.
- After reset is released: one IDLE cycle, then imem_req=1 with imem_addr=RESET_PC.
- No combinational path from inputs to any output. imem_req is decoded from state; all other outputs are registered.
- Redirect to new fetch:
  - From OUT, or from WAIT with same-cycle rvalid: the FETCH at the new target occurs in the cycle immediately after the redirect.
  - From FETCH or WAIT with no response yet: it occurs one cycle after the killed response arrives.

## Test plan
- Reset: hold reset=0 for 4 cycles with imem_rvalid toggling. All outputs must stay 0. After release: 1 cycle with imem_req=0, then imem_req=1 at addr 0x0.
- Streaming: memory latency 1, if_ready=1, words 0x00500093/0x00100113/0x002081B3 at addresses 0/4/8. Transfers must occur every 3 cycles with if_pc 0,4,8 and those words; fetch_cnt=3.
- Backpressure: if_ready=0 for 5 cycles while in OUT. if_valid=1 and if_pc/if_instr stay stable, no imem_req is issued. When if_ready rises, fetch_cnt increments and the next imem_addr is if_pc+4.
- Killed fetch: memory latency 3; redirect to 0x100 in the second WAIT cycle. The stale response must never appear on if_instr. The next imem_addr is 0x100 and the next if_pc is 0x100.
- Misaligned: redirect_pc=0x102. fetch_fault=1, if_pc=0x102, and no imem_req until reset. A later aligned redirect has no effect.
- Wrap: redirect to 0xFFFF_FFFC and complete its fetch. The next imem_addr must be 0x0000_0000.
